// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the iterative CORDIC sequencer.
package cordic_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned I_DEF     = 20;
    localparam int unsigned FRAC_BITS = 29;

    // Gain compensation 0.607252935 in Q3.29; the caller pre-scales x with it.
    localparam int unsigned K_Q329    = 326016436;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Job-in / result-out handshake bundle between the trig front end and the CORDIC sequencer.
interface cordic_iter_ctrl_if #(
    parameter int unsigned N = 32
);

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] x_in;
    logic signed [N-1:0] y_in;
    logic signed [N-1:0] z_in;

    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] x_out;
    logic signed [N-1:0] y_out;
    logic signed [N-1:0] z_out;

    // Front end: offers jobs, consumes results.
    modport master (
        output in_valid, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out
    );

    // CORDIC sequencer: accepts jobs, produces results.
    modport slave (
        input  in_valid, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out
    );

endinterface

// File: rtl/cordic_microrot.sv
// One combinational rotation-mode micro-rotation; the caller registers the results.
module cordic_microrot #(
    parameter int unsigned N  = 32,
    parameter int unsigned JW = 5
) (
    input  logic signed [N-1:0]  x,
    input  logic signed [N-1:0]  y,
    input  logic signed [N-1:0]  z,
    input  logic signed [N-1:0]  arctan,
    input  logic        [JW-1:0] j,
    output logic signed [N-1:0]  x_n,
    output logic signed [N-1:0]  y_n,
    output logic signed [N-1:0]  z_n
);

    logic signed [N-1:0] x_sh;
    logic signed [N-1:0] y_sh;
    logic                pos;

    // Direction from the sign of z (zero rotates positive); adds wrap at N bits.
    always_comb begin
        pos  = ~z[N-1];
        x_sh = x >>> j;
        y_sh = y >>> j;
        if (pos) begin
            x_n = x - y_sh;
            y_n = y + x_sh;
            z_n = z - arctan;
        end else begin
            x_n = x + y_sh;
            y_n = y - x_sh;
            z_n = z + arctan;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer: one micro-rotation per cycle, external arctan table.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    parameter  int unsigned I  = I_DEF,
    localparam int unsigned JW = $clog2(I)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_iter_ctrl_if.slave    bus,
    output logic [JW-1:0]        j,
    input  logic signed [N-1:0]  arctan,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [JW-1:0]       cnt_q, cnt_d;
    logic signed [N-1:0] x_q, y_q, z_q;
    logic signed [N-1:0] x_d, y_d, z_d;
    logic signed [N-1:0] x_rot, y_rot, z_rot;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    cordic_microrot #(
        .N  (N),
        .JW (JW)
    ) u_microrot (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .arctan (arctan),
        .j      (cnt_q),
        .x_n    (x_rot),
        .y_n    (y_rot),
        .z_n    (z_rot)
    );

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, iteration counter and datapath update; outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d     = bus.x_in;
                    y_d     = bus.y_in;
                    z_d     = bus.z_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                // Counter doubles as j, so it returns to zero on leaving RUN.
                if (cnt_q == JW'(I - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + JW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign j             = cnt_q;
    assign busy          = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.z_out     = z_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for the iterative CORDIC sequencer with an in-bench arctan table and reference loop.
module tb_cordic_iter_ctrl;

    localparam int N = 32;
    localparam int I = 20;

    localparam logic signed [31:0] K_X    = 32'sd326016436;
    localparam logic signed [31:0] PI_4   = 32'sd421657428;
    localparam logic signed [31:0] COS45  = 32'sd379625062;
    localparam logic signed [31:0] ONE    = 32'sd536870912;
    localparam logic signed [31:0] PI_Q   = 32'sd1686629713;

    logic clk;
    logic rst_n;
    logic [4:0] j;
    logic signed [N-1:0] arctan;
    logic busy;

    logic signed [31:0] atan_tab [0:31];
    int checks;
    int errors;
    logic log_en;
    int jlog [$];

    cordic_iter_ctrl_if #(.N(N)) bus ();

    cordic_iter_ctrl #(.N(N), .I(I)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .j      (j),
        .arctan (arctan),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign arctan = atan_tab[j];

    initial begin
        atan_tab[0]  = 421657428;
        atan_tab[1]  = 248918915;
        atan_tab[2]  = 131521918;
        atan_tab[3]  = 66762580;
        atan_tab[4]  = 33510844;
        atan_tab[5]  = 16771758;
        atan_tab[6]  = 8387922;
        atan_tab[7]  = 4194219;
        atan_tab[8]  = 2097141;
        atan_tab[9]  = 1048575;
        atan_tab[10] = 524288;
        atan_tab[11] = 262144;
        atan_tab[12] = 131072;
        atan_tab[13] = 65536;
        atan_tab[14] = 32768;
        atan_tab[15] = 16384;
        atan_tab[16] = 8192;
        atan_tab[17] = 4096;
        atan_tab[18] = 2048;
        atan_tab[19] = 1024;
        for (int k = 20; k < 32; k++) atan_tab[k] = 0;
    end

    // j seen mid-cycle while the datapath is rotating.
    always @(negedge clk) begin
        if (log_en && busy && !bus.out_valid) jlog.push_back(int'(j));
    end

    function automatic void model(input logic signed [31:0] xi, input logic signed [31:0] yi,
                                  input logic signed [31:0] zi, output logic signed [31:0] xo,
                                  output logic signed [31:0] yo, output logic signed [31:0] zo);
        logic signed [31:0] x, y, z, xs, ys;
        x = xi; y = yi; z = zi;
        for (int k = 0; k < I; k++) begin
            xs = x >>> k;
            ys = y >>> k;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - atan_tab[k];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[k];
            end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic run_job(input logic signed [31:0] xi, input logic signed [31:0] yi,
                           input logic signed [31:0] zi, output logic signed [31:0] xo,
                           output logic signed [31:0] yo, output logic signed [31:0] zo,
                           output int lat, output logic signed [31:0] y1);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_in_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.x_in = xi; bus.y_in = yi; bus.z_in = zi; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; y1 = '0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) y1 = bus.y_out;
        end
        xo = bus.x_out; yo = bus.y_out; zo = bus.z_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
        log_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (j !== 5'd0) begin errors++; $display("FAIL reset_j: got %0d required 0", j); end
        checks++;
        if (bus.x_out !== 0 || bus.y_out !== 0 || bus.z_out !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got %0d %0d %0d required 0 0 0", bus.x_out, bus.y_out, bus.z_out);
        end
    endtask

    task automatic test_pi4();
        logic signed [31:0] xo, yo, zo, y1, mx, my, mz;
        int lat, d;
        run_job(K_X, 0, PI_4, xo, yo, zo, lat, y1);
        model(K_X, 0, PI_4, mx, my, mz);
        checks++; if (lat !== 20) begin errors++; $display("FAIL pi4_latency: got %0d required 20", lat); end
        checks++; if (y1 !== K_X) begin errors++; $display("FAIL pi4_first_rot: y=%0d required %0d", y1, K_X); end
        d = int'(xo) - int'(COS45);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL pi4_x: got %0d required %0d +-4096", xo, COS45); end
        d = int'(yo) - int'(COS45);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL pi4_y: got %0d required %0d +-4096", yo, COS45); end
        checks++; if (zo >= 2048 || zo <= -2048) begin errors++; $display("FAIL pi4_z: got %0d required |z|<2048", zo); end
        checks++;
        if (xo !== mx || yo !== my || zo !== mz) begin
            errors++;
            $display("FAIL pi4_exact: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_zero_angle();
        logic signed [31:0] xo, yo, zo, y1, mx, my, mz;
        int lat, d;
        bit seq_ok;
        jlog.delete();
        log_en = 1'b1;
        run_job(K_X, 0, 0, xo, yo, zo, lat, y1);
        log_en = 1'b0;
        model(K_X, 0, 0, mx, my, mz);
        d = int'(xo) - int'(ONE);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL zero_x: got %0d required %0d +-4096", xo, ONE); end
        d = int'(yo);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL zero_y: got %0d required 0 +-4096", yo); end
        seq_ok = (jlog.size() == I);
        if (seq_ok) for (int k = 0; k < I; k++) if (jlog[k] != k) seq_ok = 1'b0;
        checks++; if (!seq_ok) begin errors++; $display("FAIL zero_j_sequence: got %0d entries required 0..19 consecutive", jlog.size()); end
        checks++;
        if (xo !== mx || yo !== my || zo !== mz) begin
            errors++;
            $display("FAIL zero_exact: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_neg_angle();
        logic signed [31:0] xo, yo, zo, y1, mx, my, mz;
        int lat, d;
        run_job(K_X, 0, -PI_4, xo, yo, zo, lat, y1);
        model(K_X, 0, -PI_4, mx, my, mz);
        checks++; if (y1 !== -K_X) begin errors++; $display("FAIL neg_first_rot: y=%0d required %0d", y1, -K_X); end
        d = int'(xo) - int'(COS45);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL neg_x: got %0d required %0d +-4096", xo, COS45); end
        d = int'(yo) + int'(COS45);
        checks++; if (d > 4096 || d < -4096) begin errors++; $display("FAIL neg_y: got %0d required %0d +-4096", yo, -COS45); end
        checks++;
        if (xo !== mx || yo !== my || zo !== mz) begin
            errors++;
            $display("FAIL neg_exact: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_out_of_range();
        logic signed [31:0] xo, yo, zo, y1, mx, my, mz;
        int lat;
        run_job(K_X, 32'sd100000, PI_Q, xo, yo, zo, lat, y1);
        model(K_X, 32'sd100000, PI_Q, mx, my, mz);
        checks++; if (lat !== 20) begin errors++; $display("FAIL oor_latency: got %0d required 20", lat); end
        checks++;
        if (xo !== mx || yo !== my || zo !== mz) begin
            errors++;
            $display("FAIL oor_exact: got %0d %0d %0d required %0d %0d %0d", xo, yo, zo, mx, my, mz);
        end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] cx, cy, cz, mx, my, mz;
        int w;
        bit stable;
        bus.x_in = K_X; bus.y_in = 0; bus.z_in = PI_4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 50) begin @(posedge clk); #1; w++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_rise: got %b required 1", bus.out_valid); end
        cx = bus.x_out; cy = bus.y_out; cz = bus.z_out;
        model(K_X, 0, PI_4, mx, my, mz);
        checks++;
        if (cx !== mx || cy !== my || cz !== mz) begin
            errors++;
            $display("FAIL bp_result: got %0d %0d %0d required %0d %0d %0d", cx, cy, cz, mx, my, mz);
        end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1 ||
                bus.x_out !== cx || bus.y_out !== cy || bus.z_out !== cz) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold: outputs moved or in_ready=%b out_valid=%b required stable, 0, 1", bus.in_ready, bus.out_valid); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", bus.out_valid, bus.in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] ax, ay, az, bx, by, bz;
        int w;
        bit ready_low;
        model(K_X, 0, PI_4, ax, ay, az);
        model(K_X, 0, 0, bx, by, bz);
        bus.x_in = K_X; bus.y_in = 0; bus.z_in = PI_4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.z_in = 0;
        ready_low = 1'b1;
        w = 0;
        while (!bus.out_valid && w < 50) begin
            if (bus.in_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1; w++;
        end
        if (bus.in_ready !== 1'b0) ready_low = 1'b0;
        checks++; if (!ready_low || w != 20) begin errors++; $display("FAIL b2b_busy_window: cycles=%0d ready_low=%b required 20 1", w, ready_low); end
        checks++;
        if (bus.x_out !== ax || bus.y_out !== ay || bus.z_out !== az) begin
            errors++;
            $display("FAIL b2b_first_result: got %0d %0d %0d required %0d %0d %0d", bus.x_out, bus.y_out, bus.z_out, ax, ay, az);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: in_ready=%b busy=%b required 1 0", bus.in_ready, busy);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: in_ready=%b busy=%b required 0 1", bus.in_ready, busy);
        end
        w = 0;
        while (!bus.out_valid && w < 50) begin @(posedge clk); #1; w++; end
        checks++;
        if (w != 20 || bus.x_out !== bx || bus.y_out !== by || bus.z_out !== bz) begin
            errors++;
            $display("FAIL b2b_second_result: lat=%0d got %0d %0d %0d required 20 %0d %0d %0d", w, bus.x_out, bus.y_out, bus.z_out, bx, by, bz);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic signed [31:0] xo, yo, zo, y1, mx, my, mz;
        int lat, w;
        bus.x_in = K_X; bus.y_in = 0; bus.z_in = -PI_4; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (j != 5'd7 && w < 40) begin @(posedge clk); #1; w++; end
        checks++; if (j !== 5'd7) begin errors++; $display("FAIL rst_mid_reach_j7: got j=%0d required 7", j); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || j !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: out_valid=%b in_ready=%b j=%0d busy=%b required 0 1 0 0", bus.out_valid, bus.in_ready, j, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(K_X, 0, PI_4, xo, yo, zo, lat, y1);
        model(K_X, 0, PI_4, mx, my, mz);
        checks++;
        if (lat != 20 || xo !== mx || yo !== my || zo !== mz) begin
            errors++;
            $display("FAIL rst_mid_fresh_job: lat=%0d got %0d %0d %0d required 20 %0d %0d %0d", lat, xo, yo, zo, mx, my, mz);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_pi4();
        test_zero_angle();
        test_neg_angle();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
